// File: rtl/alu_pkg.sv
// Shared definitions for the UART ALU command engine: opcodes, header size,
// operand size and the engine state encoding exported on the status LEDs.
package alu_pkg;

  localparam logic [7:0] OP_ECHO  = 8'hEC;
  localparam logic [7:0] OP_ADD32 = 8'hAD;
  localparam logic [7:0] OP_SUB32 = 8'h5B;

  localparam int HEADER_BYTES      = 4;
  localparam int DEF_OPERAND_BYTES = 4;

  // Encoding is visible on state_o[3:0], so the values are fixed.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RSV    = 4'd1,
    ST_LEN_LO = 4'd2,
    ST_LEN_HI = 4'd3,
    ST_ECHO   = 4'd4,
    ST_OPND   = 4'd5,
    ST_RESULT = 4'd6,
    ST_DRAIN  = 4'd7
  } state_e;

  function automatic logic op_known(input logic [7:0] op);
    return (op == OP_ECHO) || (op == OP_ADD32) || (op == OP_SUB32);
  endfunction

endpackage

// File: rtl/alu_accumulator.sv
// Operand assembly and add/sub accumulation for ADD32/SUB32 packets.
// Bytes arrive LSB first; every OPERAND_BYTES-th byte completes a word that
// either seeds the accumulator (first word) or is added/subtracted into it.
module alu_accumulator
  import alu_pkg::*;
#(
  parameter int OPERAND_BYTES = DEF_OPERAND_BYTES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 data_byte,
  input  logic                       byte_valid,
  input  logic                       first,
  input  logic                       op_sub,
  input  logic                       clear,
  output logic [8*OPERAND_BYTES-1:0] acc,
  output logic                       word_done
);
  localparam int ACC_W = 8 * OPERAND_BYTES;
  localparam int CNT_W = $clog2(OPERAND_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OPERAND_BYTES - 1);

  logic [ACC_W-1:0] opnd;
  logic [ACC_W-1:0] word;
  logic [CNT_W-1:0] byte_cnt;

  // Modulo-2^ACC_W add or subtract; carry/borrow is intentionally dropped.
  function automatic logic [ACC_W-1:0] wrap_addsub(input logic [ACC_W-1:0] a,
                                                   input logic [ACC_W-1:0] b,
                                                   input logic             sub);
    return sub ? (a - b) : (a + b);
  endfunction

  // The incoming byte lands in the top lane, so after a full word the first
  // byte received sits in bits [7:0].
  assign word      = {data_byte, opnd[ACC_W-1:8]};
  assign word_done = byte_valid && (byte_cnt == LAST_IDX);

  // Shift register, byte counter and accumulator update.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      opnd     <= '0;
      byte_cnt <= '0;
      acc      <= '0;
    end else if (byte_valid) begin
      opnd     <= word;
      byte_cnt <= word_done ? '0 : byte_cnt + 1'b1;
      if (word_done) begin
        acc <= first ? word : wrap_addsub(acc, word, op_sub);
      end
    end
  end

endmodule

// File: rtl/alu_cmd_engine.sv
// Packet command engine between the UART RX and TX byte streams.
// Decodes a 4-byte header (opcode, reserved, LEN lo, LEN hi), then echoes the
// payload or folds it into a 32-bit ADD/SUB result returned little-endian.
module alu_cmd_engine
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int OPERAND_BYTES = DEF_OPERAND_BYTES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [4:0]            state_o
);
  localparam int ACC_W = 8 * OPERAND_BYTES;
  localparam int RES_W = $clog2(OPERAND_BYTES) + 1;
  localparam logic [RES_W-1:0] RES_LAST = RES_W'(OPERAND_BYTES);

  state_e           state;
  logic             err;
  logic [7:0]       opcode;
  logic [7:0]       len_lo;
  logic [15:0]      remaining;
  logic             first_word;
  logic [RES_W-1:0] res_cnt;

  logic             in_xfer;
  logic             out_xfer;
  logic [15:0]      len_total;
  logic [15:0]      payload;
  logic             acc_clear;
  logic             acc_feed;
  logic             word_done;
  logic [ACC_W-1:0] acc;

  function automatic logic [7:0] acc_byte(input logic [ACC_W-1:0] a,
                                          input logic [RES_W-1:0] idx);
    logic [ACC_W-1:0] s;
    s = a >> (8 * idx);
    return s[7:0];
  endfunction

  assign in_xfer   = valid_i && ready_o;
  assign out_xfer  = valid_o && ready_i;
  assign len_total = {data_i, len_lo};
  assign payload   = len_total - 16'(HEADER_BYTES);
  assign acc_clear = in_xfer && (state == ST_LEN_HI);
  assign acc_feed  = in_xfer && (state == ST_OPND);
  assign state_o   = {err, state};

  alu_accumulator #(
    .OPERAND_BYTES(OPERAND_BYTES)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .data_byte (data_i),
    .byte_valid(acc_feed),
    .first     (first_word),
    .op_sub    (opcode == OP_SUB32),
    .clear     (acc_clear),
    .acc       (acc),
    .word_done (word_done)
  );

  // Input acceptance: ECHO only takes a byte when the output register is free
  // or freeing this cycle; RESULT takes nothing while streaming the answer.
  always_comb begin
    ready_o = 1'b1;
    unique case (state)
      ST_ECHO:   ready_o = !valid_o || ready_i;
      ST_RESULT: ready_o = 1'b0;
      default:   ready_o = 1'b1;
    endcase
  end

  // Packet FSM, length counter, sticky error and the registered output byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      err        <= 1'b0;
      opcode     <= '0;
      len_lo     <= '0;
      remaining  <= '0;
      first_word <= 1'b0;
      res_cnt    <= '0;
      valid_o    <= 1'b0;
      data_o     <= '0;
    end else begin
      // A load later in this block overrides the release below.
      if (out_xfer) valid_o <= 1'b0;
      if (word_done) first_word <= 1'b0;

      unique case (state)
        ST_IDLE: if (in_xfer) begin
          opcode <= data_i;
          state  <= ST_RSV;
        end
        ST_RSV: if (in_xfer) state <= ST_LEN_LO;
        ST_LEN_LO: if (in_xfer) begin
          len_lo <= data_i;
          state  <= ST_LEN_HI;
        end
        ST_LEN_HI: if (in_xfer) begin
          remaining  <= payload;
          first_word <= 1'b1;
          res_cnt    <= '0;
          if (len_total < 16'(HEADER_BYTES)) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else if (!op_known(opcode)) begin
            // Nothing left to discard when the header was the whole packet.
            err   <= 1'b1;
            state <= (payload == 16'd0) ? ST_IDLE : ST_DRAIN;
          end else if (opcode == OP_ECHO) begin
            state <= (payload == 16'd0) ? ST_IDLE : ST_ECHO;
          end else if (payload == 16'd0) begin
            state <= ST_RESULT;
          end else if ((payload % 16'(OPERAND_BYTES)) != 16'd0) begin
            err   <= 1'b1;
            state <= ST_DRAIN;
          end else begin
            state <= ST_OPND;
          end
        end
        ST_ECHO: if (in_xfer) begin
          data_o    <= data_i;
          valid_o   <= 1'b1;
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) state <= ST_IDLE;
        end
        ST_OPND: if (in_xfer) begin
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) state <= ST_RESULT;
        end
        ST_RESULT: begin
          // A leftover ECHO byte may still occupy the register on entry.
          if ((res_cnt != RES_LAST) && (!valid_o || ready_i)) begin
            data_o  <= acc_byte(acc, res_cnt);
            valid_o <= 1'b1;
            res_cnt <= res_cnt + 1'b1;
          end else if ((res_cnt == RES_LAST) && out_xfer) begin
            state <= ST_IDLE;
          end
        end
        ST_DRAIN: if (in_xfer) begin
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_engine.sv
// Scoreboard bench for alu_cmd_engine: stimulus pushes the bytes a packet
// should produce, a negedge monitor pops and compares on every output transfer.
module tb_alu_cmd_engine;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic [4:0] state_o;

  int         checks = 0;
  int         passes = 0;
  logic [7:0] exp_q[$];
  logic       exp_err = 1'b0;
  int         ready_mode = 0;
  logic       ready_man = 1'b1;
  int         cyc = 0;
  int         xfer_cyc[$];
  logic       stall_pend = 1'b0;
  logic [7:0] stall_data = 8'h00;

  alu_cmd_engine dut (
    .clk    (clk),
    .rst    (rst),
    .data_i (data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Downstream ready: 0 always high, 1 toggling, 2 random, 3 manual.
  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: ready_i = 1'b1;
        1: ready_i = !ready_i;
        2: ready_i = ($urandom_range(0, 3) != 0);
        default: ready_i = ready_man;
      endcase
    end
  end

  // Monitor: compares every output transfer and checks stalled bytes hold.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (stall_pend) begin
        check("hold_valid", 32'(valid_o), 32'd1);
        check("hold_data", 32'(data_o), 32'(stall_data));
        stall_pend = 1'b0;
      end
      if (valid_o && ready_i) begin
        xfer_cyc.push_back(cyc);
        check("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("out_byte", 32'(data_o), 32'(exp_q.pop_front()));
      end else if (valid_o && !ready_i && !rst) begin
        stall_pend = 1'b1;
        stall_data = data_o;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Behavioural model: what a whole packet should produce.
  task automatic model_pkt(input bq_t pkt);
    int len, pay;
    logic [31:0] acc, w;
    len = int'({pkt[3], pkt[2]});
    if (len < 4) begin
      exp_err = 1'b1;
      return;
    end
    pay = len - 4;
    if (pkt[0] == 8'hEC) begin
      for (int i = 0; i < pay; i++) exp_q.push_back(pkt[4+i]);
    end else if (pkt[0] == 8'hAD || pkt[0] == 8'h5B) begin
      if (pay % 4 != 0) exp_err = 1'b1;
      else begin
        acc = 32'd0;
        for (int k = 0; k < pay / 4; k++) begin
          w = {pkt[4+4*k+3], pkt[4+4*k+2], pkt[4+4*k+1], pkt[4+4*k]};
          if (k == 0) acc = w;
          else if (pkt[0] == 8'hAD) acc = acc + w;
          else acc = acc - w;
        end
        for (int b = 0; b < 4; b++) exp_q.push_back(acc[8*b +: 8]);
      end
    end else begin
      exp_err = 1'b1;
    end
  endtask

  // Entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    valid_i = 1'b1;
    data_i  = b;
    budget  = 0;
    forever begin
      @(negedge clk);
      if (ready_o) break;
      budget++;
      if (budget > 200) begin
        check("accept_timeout", 32'(ready_o), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic send_pkt(input bq_t pkt, input bit gaps);
    model_pkt(pkt);
    foreach (pkt[i]) send_byte(pkt[i], gaps);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    check({name, "_state"}, 32'(state_o), 32'({exp_err, 4'd0}));
    check({name, "_ready"}, 32'(ready_o), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic random_pkt(output bq_t pkt);
    int kind, pay, len;
    logic [7:0] op;
    pkt  = {};
    kind = int'($urandom_range(0, 9));
    case (kind)
      0, 1, 2: begin op = 8'hEC; pay = int'($urandom_range(0, 8)); end
      3, 4, 5: begin op = 8'hAD; pay = 4 * int'($urandom_range(0, 3)); end
      6, 7:    begin op = 8'h5B; pay = 4 * int'($urandom_range(0, 3)); end
      8: begin
        op = 8'($urandom);
        if (op == 8'hEC || op == 8'hAD || op == 8'h5B) op = op ^ 8'h01;
        pay = int'($urandom_range(0, 5));
      end
      default: begin
        op  = ($urandom_range(0, 1) != 0) ? 8'hAD : 8'h5B;
        pay = int'($urandom_range(1, 7));
        if (pay % 4 == 0) pay = 3;
      end
    endcase
    len = pay + 4;
    if (kind == 9 && $urandom_range(0, 2) == 0) len = int'($urandom_range(0, 3));
    pkt.push_back(op);
    pkt.push_back(8'($urandom));
    pkt.push_back(8'(len));
    pkt.push_back(8'(len >> 8));
    for (int i = 0; i < len - 4; i++) pkt.push_back(8'($urandom));
  endtask

  initial begin
    bq_t pkt;
    int  n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    @(posedge clk);
    #1;

    // ECHO at full throughput
    xfer_cyc.delete();
    send_pkt('{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43}, 1'b0);
    wait_drain("echo");
    check("echo_count", 32'(xfer_cyc.size()), 32'd3);
    if (xfer_cyc.size() == 3) check("echo_rate", 32'(xfer_cyc[2] - xfer_cyc[0]), 32'd2);

    // ADD32 with wrap, immediately followed by SUB32
    send_pkt('{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
               8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1'b0);
    send_pkt('{8'h5B, 8'h00, 8'h10, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00,
               8'h03, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00}, 1'b0);
    wait_drain("addsub");

    // Backpressure on ECHO
    ready_mode = 1;
    send_pkt('{8'hEC, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB}, 1'b0);
    wait_drain("bp_echo");
    ready_mode = 0;

    // Error packets, then a good ECHO
    send_pkt('{8'h77, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22}, 1'b0);
    wait_drain("bad_op");
    send_pkt('{8'hAD, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03}, 1'b0);
    wait_drain("bad_len");
    send_pkt('{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A}, 1'b1);
    wait_drain("echo_after_err");

    // Reset after the first result byte transfers
    ready_mode = 3;
    ready_man  = 1'b0;
    exp_q.push_back(8'h78);
    foreach (pkt[i]) pkt.delete(i);
    pkt = '{8'hAD, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    foreach (pkt[i]) send_byte(pkt[i], 1'b0);
    n = 0;
    while (!valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_valid", 32'(valid_o), 32'd1);
    @(posedge clk);
    #1;
    ready_man = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    ready_man = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    check("rst_mid_valid_o", 32'(valid_o), 32'd0);
    check("rst_mid_ready_o", 32'(ready_o), 32'd1);
    check("rst_mid_state", 32'(state_o), 32'd0);
    check("rst_mid_popped", 32'(exp_q.size()), 32'd0);
    ready_man = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    ready_mode = 0;

    // Randomized packets, back to back in small batches
    for (int p = 0; p < 40; p++) begin
      ready_mode = int'($urandom_range(0, 2));
      random_pkt(pkt);
      send_pkt(pkt, ($urandom_range(0, 1) != 0));
      if (p % 5 == 4) wait_drain("random");
    end
    ready_mode = 0;
    wait_drain("final");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_cmd_engine.md
Name: alu_cmd_engine

Overview:
- Packet-level command processor between the RX-side byte pipeline and the TX-side byte pipeline of the UART ALU.
- Consumes a byte stream from the UART receiver and decodes a 4-byte header.
- Executes ECHO, ADD32 or SUB32 on little-endian 32-bit operands.
- Emits the response bytes over a valid/ready byte stream to the transmitter; exports a 5-bit status for the board LEDs.

Parameters:
- DATA_WIDTH, 8, stream byte width (fixed at 8; other values unsupported)
- OPERAND_BYTES, 4, bytes per operand and per result

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- data_i  input  8  received byte
- valid_i  input  1  data_i valid
- ready_o  output  1  engine accepts data_i this cycle
- data_o  output  8  response byte
- valid_o  output  1  data_o valid
- ready_i  input  1  downstream accepts data_o
- state_o  output  5  [3:0] state code, [4] sticky error flag

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high. Reset mid-operation aborts the packet with no partial output.
- Reset values: ready_o=1, valid_o=0, data_o=0x00, state_o=5'b0_0000, accumulator=0, length=0.
- Transfers: an input byte transfers when valid_i&&ready_o; an output byte transfers when valid_o&&ready_i.
- Output register: data_o/valid_o are registered. Once valid_o=1, data_o holds stable until it transfers.
- Packet format: byte0 opcode, byte1 reserved (ignored), byte2 LEN[7:0], byte3 LEN[15:8]. LEN is the total packet bytes including the header; payload = LEN-4.
- Opcodes: ECHO=0xEC, ADD32=0xAD, SUB32=0x5B; anything else is invalid.
- State codes:
  - IDLE=0: wait for opcode.
  - RSV=1: consume the reserved byte.
  - LEN_LO=2.
  - LEN_HI=3.
  - ECHO=4.
  - OPND=5.
  - RESULT=6.
  - DRAIN=7.
- Header: IDLE->RSV->LEN_LO->LEN_HI, one accepted byte per transition; ready_o=1 throughout. On the LEN_HI transfer, payload = {data_i,len_lo}-4 is computed and the next state is chosen:
  - LEN<4: sticky error, go to IDLE, no output.
  - payload==0 with ECHO: go to IDLE.
  - payload==0 with ADD32/SUB32: go to RESULT with accumulator=0.
  - invalid opcode, or ADD/SUB with payload%4!=0: sticky error, go to DRAIN.
  - otherwise ECHO->ECHO, ADD/SUB->OPND.
- ECHO:
  - ready_o = !valid_o || ready_i.
  - Each accepted byte appears on data_o with valid_o=1 the next cycle. Full throughput is one byte per cycle when ready_i stays high.
  - Decrement the remaining count per accepted byte; after the last byte go to IDLE. The output register still drains normally.
- OPND:
  - ready_o=1; bytes are shifted into a 32-bit operand register LSB first.
  - On every 4th byte: the first operand loads the accumulator; later operands apply acc=acc+opnd (ADD32) or acc=acc-opnd (SUB32).
  - Arithmetic is modulo 2^32; no carry or borrow is reported.
  - After the final payload byte, go to RESULT.
- RESULT:
  - ready_o=0.
  - Emit acc[7:0], acc[15:8], acc[23:16], acc[31:24] in order; each byte advances only on its transfer.
  - After the 4th transfer, go to IDLE; ready_o=1 on the following cycle.
- DRAIN: ready_o=1; discard the remaining payload bytes with no output, then go to IDLE.
- Stall: valid_i low in any state holds the state and all counters.
- Sticky error (state_o[4]): set as above; cleared only by rst. Never blocks later packets.
- Simultaneous events: the last ECHO input and a pending output transfer in the same cycle are both honoured.
- No latency between packets: an opcode is accepted the cycle after entering IDLE.

Decomposition:
- alu_pkg:
  - opcode localparams (OP_ECHO, OP_ADD32, OP_SUB32)
  - state enum (5 bits wide is not needed; 4-bit state_e)
  - HEADER_BYTES=4
  - OPERAND_BYTES default
- Sub-module alu_accumulator:
  - 32-bit operand shift register, byte counter, add/sub datapath, accumulator.
  - Inputs: byte, byte_valid, first, op_sub, clear.
  - Output: acc, word_done.
- The engine FSM, length counter and output register stay in alu_cmd_engine.

Test Plan:
- ECHO: send EC 00 07 00 41 42 43 with ready_i=1 -> output 41 42 43, one per cycle. state_o returns to 0; error=0.
- ADD32: send AD 00 0C 00 01 00 00 00 FF FF FF FF -> output 00 00 00 00 (wrap). Then the next packet is accepted immediately.
- SUB32: send 5B 00 10 00, then 10 00 00 00, 03 00 00 00, 02 00 00 00 -> output 0B 00 00 00.
- Backpressure: ECHO payload AA BB with ready_i toggling 0/1 every cycle -> data_o held stable while stalled; output AA BB exactly once; no byte lost.
- Errors:
  - opcode 0x77 with LEN=6, then 2 payload bytes -> no output, state_o[4]=1.
  - ADD with LEN=7 -> drains 3 bytes; error stays set.
  - A following valid ECHO still works.
- Reset mid-RESULT: assert rst after the first result byte transfers -> valid_o=0, ready_o=1, state_o=0 the next cycle; no further bytes emitted.
